// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite queued write master.
//   - BRESP encodings
//   - write-master FSM state enum
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/axi_lite_cmd_fifo.sv
// Synchronous command FIFO for the queued AXI-Lite writer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointers/occupancy only)
//   push      : write request; lands when not full, or when a pop frees a slot
//   pop       : read request; ignored while empty
//   wdata     : entry to store
//   rdata     : head entry, read from the register array
//   full/empty: occupancy flags
//   fill      : number of stored entries, 0..DEPTH
module axi_lite_cmd_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (fill == FW'(DEPTH));
  assign empty = (fill == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + FW'(do_push) - FW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axi_lite_queued_writer.sv
// AXI4-Lite write master fed by a command queue.
// Each queued command becomes one AW + one W transfer issued concurrently,
// followed by a B response. Non-OKAY responses re-issue the same command up
// to MAX_RETRY times; one Done pulse (with Done_Err) closes every command.
// Ports:
//   ACLK, ARESET         : clock, synchronous active-high reset
//   AW*/W*/B*            : AXI4-Lite write channels (master side)
//   Cmd_Valid/Ready/...  : command push interface (address, data, strobes)
//   Done, Done_Err       : one-cycle completion pulse and final error status
//   Busy, Fill           : activity flag and queue occupancy
module axi_lite_queued_writer
  import axi_lite_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter int         DEPTH     = 4,
  parameter int         MAX_RETRY = 2,
  parameter logic [2:0] PROT      = 3'b000
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  output logic [ADDR_W-1:0]          AWADDR,
  output logic [2:0]                 AWPROT,
  output logic                       WVALID,
  input  logic                       WREADY,
  output logic [DATA_W-1:0]          WDATA,
  output logic [DATA_W/8-1:0]        WSTRB,
  input  logic                       BVALID,
  output logic                       BREADY,
  input  logic [1:0]                 BRESP,
  input  logic                       Cmd_Valid,
  output logic                       Cmd_Ready,
  input  logic [ADDR_W-1:0]          Cmd_Addr,
  input  logic [DATA_W-1:0]          Cmd_Data,
  input  logic [DATA_W/8-1:0]        Cmd_Strb,
  output logic                       Done,
  output logic                       Done_Err,
  output logic                       Busy,
  output logic [$clog2(DEPTH+1)-1:0] Fill
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CMD_W  = ADDR_W + DATA_W + STRB_W;
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTY_W-1:0] MAX_R = RTY_W'(MAX_RETRY);

  state_t             state;
  state_t             state_n;
  logic [RTY_W-1:0]   retry;
  logic [RTY_W-1:0]   retry_n;
  logic               awvalid_n;
  logic               wvalid_n;
  logic               bready_n;
  logic               done_n;
  logic               err_n;
  logic               load;

  logic [CMD_W-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;

  axi_lite_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (Cmd_Valid),
    .pop   (state == ST_IDLE),
    .wdata ({Cmd_Addr, Cmd_Data, Cmd_Strb}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (Fill)
  );

  assign Cmd_Ready = !fifo_full;
  assign Busy      = (state != ST_IDLE) || !fifo_empty;
  assign AWPROT    = PROT;

  always_comb begin
    state_n   = state;
    retry_n   = retry;
    awvalid_n = AWVALID;
    wvalid_n  = WVALID;
    bready_n  = BREADY;
    done_n    = 1'b0;
    err_n     = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load      = 1'b1;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          retry_n   = '0;
          state_n   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // AW and W complete independently; B is only accepted once both are done.
        if (AWREADY) awvalid_n = 1'b0;
        if (WREADY)  wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n  = ST_RESP;
        end
      end
      ST_RESP: begin
        // BREADY is held high for the whole state, so BVALID alone is the handshake.
        if (BVALID) begin
          bready_n = 1'b0;
          if (BRESP == RESP_OKAY) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else if (retry < MAX_R) begin
            retry_n   = retry + 1'b1;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = ST_ISSUE;
          end else begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= ST_IDLE;
      retry    <= '0;
      AWVALID  <= 1'b0;
      WVALID   <= 1'b0;
      BREADY   <= 1'b0;
      Done     <= 1'b0;
      Done_Err <= 1'b0;
      AWADDR   <= '0;
      WDATA    <= '0;
      WSTRB    <= '0;
    end else begin
      state    <= state_n;
      retry    <= retry_n;
      AWVALID  <= awvalid_n;
      WVALID   <= wvalid_n;
      BREADY   <= bready_n;
      Done     <= done_n;
      Done_Err <= err_n;
      if (load) {AWADDR, WDATA, WSTRB} <= head;
    end
  end

endmodule

// File: tb/tb_axi_lite_queued_writer.sv
module tb_axi_lite_queued_writer;
  import axi_lite_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA;
  logic [2:0]  AWPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP;
  logic        Cmd_Valid, Cmd_Ready;
  logic [31:0] Cmd_Addr, Cmd_Data;
  logic [3:0]  Cmd_Strb;
  logic        Done, Done_Err, Busy;
  logic [2:0]  Fill;

  logic        AWVALID64, AWREADY64, WVALID64, WREADY64, BVALID64, BREADY64;
  logic [31:0] AWADDR64, Cmd_Addr64;
  logic [63:0] WDATA64, Cmd_Data64;
  logic [2:0]  AWPROT64;
  logic [7:0]  WSTRB64, Cmd_Strb64;
  logic [1:0]  BRESP64;
  logic        Cmd_Valid64, Cmd_Ready64, Done64, Done_Err64, Busy64;
  logic [2:0]  Fill64;

  always #5 ACLK = ~ACLK;

  axi_lite_queued_writer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .MAX_RETRY(2), .PROT(3'b000)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Addr(Cmd_Addr),
    .Cmd_Data(Cmd_Data), .Cmd_Strb(Cmd_Strb),
    .Done(Done), .Done_Err(Done_Err), .Busy(Busy), .Fill(Fill)
  );

  axi_lite_queued_writer #(.ADDR_W(32), .DATA_W(64), .DEPTH(2), .MAX_RETRY(0), .PROT(3'b010)) dut64 (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID64), .AWREADY(AWREADY64), .AWADDR(AWADDR64), .AWPROT(AWPROT64),
    .WVALID(WVALID64), .WREADY(WREADY64), .WDATA(WDATA64), .WSTRB(WSTRB64),
    .BVALID(BVALID64), .BREADY(BREADY64), .BRESP(BRESP64),
    .Cmd_Valid(Cmd_Valid64), .Cmd_Ready(Cmd_Ready64), .Cmd_Addr(Cmd_Addr64),
    .Cmd_Data(Cmd_Data64), .Cmd_Strb(Cmd_Strb64),
    .Done(Done64), .Done_Err(Done_Err64), .Busy(Busy64), .Fill(Fill64)
  );

  int checks = 0;
  int errors = 0;

  // slave model configuration and observation
  int          aw_lat, w_lat, b_lat, aw_cnt, w_cnt, b_cnt;
  int          nresp, resp_idx;
  logic [5:0]  resp_seq;
  logic        stall, bstall;
  int          n_done, viol;
  logic        last_err;
  logic [31:0] aw_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_clear();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; resp_idx = 0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = RESP_OKAY;
  endtask

  // One clock: log handshakes of the edge, monitor protocol, drive next slave inputs.
  task automatic step();
    logic p_aw, p_w, p_b, p_awv, p_wv, p_rst;
    logic [31:0] p_addr, p_data;
    logic [3:0]  p_strb;
    p_aw = AWVALID && AWREADY; p_w = WVALID && WREADY; p_b = BVALID && BREADY;
    p_awv = AWVALID; p_wv = WVALID; p_rst = ARESET;
    p_addr = AWADDR; p_data = WDATA; p_strb = WSTRB;
    @(posedge ACLK); #1;
    if (p_rst !== 1'b1) begin
      if (p_aw === 1'b1) begin aw_q.push_back(p_addr); aw_cnt = 0; end
      if (p_w === 1'b1) begin wd_q.push_back(p_data); ws_q.push_back(p_strb); w_cnt = 0; end
      if (p_awv === 1'b1 && p_aw !== 1'b1 && (AWVALID !== 1'b1 || AWADDR !== p_addr)) viol++;
      if (p_wv === 1'b1 && p_w !== 1'b1 && (WVALID !== 1'b1 || WDATA !== p_data || WSTRB !== p_strb)) viol++;
      if (p_b === 1'b1) begin resp_idx++; b_cnt = 0; end
    end
    if (BREADY === 1'b1 && (AWVALID === 1'b1 || WVALID === 1'b1)) viol++;
    if (Done === 1'b1) begin n_done++; last_err = Done_Err; end
    AWREADY = (AWVALID === 1'b1) && !stall && (aw_cnt >= aw_lat);
    WREADY  = (WVALID === 1'b1) && !stall && (w_cnt >= w_lat);
    BVALID  = (BREADY === 1'b1) && !bstall && (b_cnt >= b_lat);
    BRESP   = (resp_idx < nresp) ? resp_seq[2*resp_idx +: 2] : RESP_OKAY;
    if (AWVALID === 1'b1) aw_cnt++;
    if (WVALID === 1'b1) w_cnt++;
    if (BREADY === 1'b1) b_cnt++;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    Cmd_Addr = a; Cmd_Data = d; Cmd_Strb = s; Cmd_Valid = 1'b1;
    step();
    Cmd_Valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_lat, w_lat, b_lat;
    int          nresp;
    logic [5:0]  resp_seq;
    logic        exp_err;
    int          exp_issues;
  } vec_t;

  vec_t vecs[7];
  int   exp_fill[5] = '{1, 1, 2, 3, 4};

  initial begin
    int done0, mism;

    vecs[0] = '{32'h0000_0010, 32'hA5A5_1234, 4'hF, 0, 0, 0, 0, 6'b000000, 1'b0, 1};
    vecs[1] = '{32'h0000_0020, 32'h0BAD_F00D, 4'h3, 3, 0, 0, 0, 6'b000000, 1'b0, 1};
    vecs[2] = '{32'h0000_0024, 32'h1357_9BDF, 4'hC, 0, 3, 1, 0, 6'b000000, 1'b0, 1};
    vecs[3] = '{32'h0000_0030, 32'hDEAD_BEEF, 4'hF, 1, 2, 0, 3, {RESP_OKAY, RESP_SLVERR, RESP_SLVERR}, 1'b0, 3};
    vecs[4] = '{32'h0000_0034, 32'hCAFE_0001, 4'h1, 0, 0, 0, 3, {RESP_SLVERR, RESP_SLVERR, RESP_SLVERR}, 1'b1, 3};
    vecs[5] = '{32'h0000_0040, 32'h0000_0000, 4'h0, 2, 2, 2, 1, {RESP_OKAY, RESP_OKAY, RESP_DECERR}, 1'b0, 2};
    vecs[6] = '{32'hFFFF_FFFC, 32'h8000_0001, 4'h5, 0, 1, 0, 3, {RESP_EXOKAY, RESP_EXOKAY, RESP_EXOKAY}, 1'b1, 3};

    aw_lat = 0; w_lat = 0; b_lat = 0; nresp = 0; resp_seq = '0;
    stall = 1'b0; bstall = 1'b0; n_done = 0; viol = 0; last_err = 1'b0;
    Cmd_Valid = 1'b0; Cmd_Addr = '0; Cmd_Data = '0; Cmd_Strb = '0;
    Cmd_Valid64 = 1'b0; Cmd_Addr64 = '0; Cmd_Data64 = '0; Cmd_Strb64 = '0;
    AWREADY64 = 1'b1; WREADY64 = 1'b1; BVALID64 = 1'b1; BRESP64 = RESP_OKAY;
    slave_clear();

    // reset state
    ARESET = 1'b1;
    repeat (3) step();
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_done", {Done, Done_Err}, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_fill", Fill, 0);
    chk("rst_cmd_ready", Cmd_Ready, 1);
    chk("rst_bus", {AWADDR, WDATA, WSTRB}, 0);
    ARESET = 1'b0;
    step();
    n_done = 0; viol = 0;

    // single write, zero-wait slave, cycle-exact
    push(32'h0000_0010, 32'hA5A5_1234, 4'hF);
    chk("t_push_fill", Fill, 1);
    chk("t_push_awvalid", AWVALID, 0);
    step();
    chk("t_pop_valids", {AWVALID, WVALID, BREADY}, 3'b110);
    chk("t_pop_bus", {AWADDR, WDATA, WSTRB}, {32'h0000_0010, 32'hA5A5_1234, 4'hF});
    chk("t_pop_fill", Fill, 0);
    step();
    chk("t_hs_valids", {AWVALID, WVALID, BREADY}, 3'b001);
    chk("t_hs_logged", {aw_q.size(), wd_q.size()}, {32'd1, 32'd1});
    step();
    chk("t_done", {Done, Done_Err, BREADY}, 3'b100);
    chk("t_done_busy", Busy, 0);
    step();
    chk("t_done_one_cycle", Done, 0);
    aw_q.delete(); wd_q.delete(); ws_q.delete();

    // table-driven single commands
    for (int i = 0; i < 7; i++) begin
      aw_lat = vecs[i].aw_lat; w_lat = vecs[i].w_lat; b_lat = vecs[i].b_lat;
      nresp = vecs[i].nresp; resp_seq = vecs[i].resp_seq; resp_idx = 0;
      aw_q.delete(); wd_q.delete(); ws_q.delete();
      viol = 0; done0 = n_done;
      push(vecs[i].addr, vecs[i].data, vecs[i].strb);
      for (int c = 0; c < 100 && n_done == done0; c++) step();
      chk($sformatf("v%0d_done", i), n_done - done0, 1);
      chk($sformatf("v%0d_err", i), last_err, vecs[i].exp_err);
      chk($sformatf("v%0d_aw_count", i), aw_q.size(), vecs[i].exp_issues);
      chk($sformatf("v%0d_w_count", i), wd_q.size(), vecs[i].exp_issues);
      mism = 0;
      foreach (aw_q[k]) if (aw_q[k] !== vecs[i].addr) mism++;
      foreach (wd_q[k]) if (wd_q[k] !== vecs[i].data || ws_q[k] !== vecs[i].strb) mism++;
      chk($sformatf("v%0d_payload_mism", i), mism, 0);
      step(); step();
      chk($sformatf("v%0d_single_done", i), n_done - done0, 1);
      chk($sformatf("v%0d_protocol", i), viol, 0);
    end

    // queue fill with stalled slave, then drain in order
    aw_lat = 0; w_lat = 0; b_lat = 0; nresp = 0; resp_idx = 0;
    aw_q.delete(); wd_q.delete(); ws_q.delete();
    viol = 0; done0 = n_done; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(32'h0000_1000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF);
      chk($sformatf("q_fill%0d", i), Fill, exp_fill[i]);
    end
    chk("q_cmd_ready_full", Cmd_Ready, 0);
    chk("q_busy", Busy, 1);
    push(32'h0000_0999, 32'h9999_9999, 4'hF);
    chk("q_push_full_ignored", Fill, 4);
    stall = 1'b0;
    for (int c = 0; c < 300 && (n_done - done0) < 5; c++) step();
    repeat (4) step();
    chk("q_done_count", n_done - done0, 5);
    chk("q_issue_count", aw_q.size(), 5);
    mism = 0;
    foreach (aw_q[k]) if (aw_q[k] !== 32'h0000_1000 + 32'(k * 4)) mism++;
    chk("q_order_mism", mism, 0);
    chk("q_drained_fill", {Fill, Busy, Cmd_Ready}, 5'b00001);
    chk("q_protocol", viol, 0);

    // reset while waiting for B with two commands queued
    bstall = 1'b1; done0 = n_done;
    push(32'h0000_2000, 32'h2, 4'hF);
    push(32'h0000_2004, 32'h3, 4'hF);
    push(32'h0000_2008, 32'h4, 4'hF);
    for (int c = 0; c < 20 && BREADY !== 1'b1; c++) step();
    chk("r_pre_state", {BREADY, Fill}, {1'b1, 3'd2});
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    slave_clear();
    chk("r_valids", {AWVALID, WVALID, BREADY}, 0);
    chk("r_fill_busy", {Fill, Busy, Cmd_Ready}, 5'b00001);
    bstall = 1'b0;
    repeat (4) step();
    chk("r_no_done", n_done - done0, 0);
    chk("r_queue_discarded", {AWVALID, Fill}, 0);

    // 64-bit data path
    Cmd_Addr64 = 32'h0000_0080; Cmd_Data64 = 64'h1122_3344_5566_7788; Cmd_Strb64 = 8'h0F;
    Cmd_Valid64 = 1'b1;
    step();
    Cmd_Valid64 = 1'b0;
    step();
    chk("w64_valids", {AWVALID64, WVALID64}, 2'b11);
    chk("w64_wdata", WDATA64, 64'h1122_3344_5566_7788);
    chk("w64_wstrb", WSTRB64, 8'h0F);
    chk("w64_addr_prot", {AWADDR64, AWPROT64}, {32'h0000_0080, 3'b010});
    step();
    chk("w64_bready", BREADY64, 1);
    step();
    chk("w64_done", {Done64, Done_Err64}, 2'b10);
    chk("w64_idle", {Busy64, Fill64, Cmd_Ready64}, 5'b00001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
